// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
// State encodings and the done-counter ceiling.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    localparam logic [7:0] DONE_CNT_MAX = 8'd255;

endpackage

// File: rtl/down_counter_core.sv
// Loadable down-counter register with reload-on-zero.
// Load beats enable; enabled at zero it reloads or holds, never wraps.
module down_counter_core
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_en,
    input  logic             i_reload,
    input  logic [WIDTH-1:0] i_reload_value,
    output logic [WIDTH-1:0] o_count,
    output logic             o_is_one,
    output logic             o_is_zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign o_count   = cnt_q;
    assign o_is_zero = (cnt_q == '0);
    assign o_is_one  = (cnt_q == WIDTH'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_value;
        end else if (i_en) begin
            if (!o_is_zero) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else if (i_reload) begin
                cnt_d = i_reload_value;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A wrap from zero to all-ones outside a load is a logic bug.
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(!i_load && cnt_q == '0 && cnt_d == '1 && !(i_en && i_reload))
    ) else $error("down_counter_core: count underflow");

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer: IDLE/RUN/PAUSED FSM, done pulse, done counter.
// COUNTDOWN_TIMER_TICK_EN adds i_tick to gate RUN-state advancement.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_LOAD = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_auto_reload,
`ifdef COUNTDOWN_TIMER_TICK_EN
    input  logic             i_tick,
`endif
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_done_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic [7:0]       done_cnt_q, done_cnt_d;

    logic             tick;
    logic             start_reload;
    logic             core_load;
    logic [WIDTH-1:0] core_load_value;
    logic             core_en;
    logic             is_one;
    logic             is_zero;

`ifdef COUNTDOWN_TIMER_TICK_EN
    assign tick = i_tick;
`else
    assign tick = 1'b1;
`endif

    down_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_load         (core_load),
        .i_load_value   (core_load_value),
        .i_en           (core_en),
        .i_reload       (i_auto_reload),
        .i_reload_value (reload_q),
        .o_count        (o_count),
        .o_is_one       (is_one),
        .o_is_zero      (is_zero)
    );

    always_comb begin
        state_d         = state_q;
        reload_d        = reload_q;
        done_d          = 1'b0;
        start_reload    = 1'b0;
        core_load       = 1'b0;
        core_load_value = i_load_value;
        core_en         = 1'b0;

        if (i_stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end else if (state_q == ST_PAUSED) begin
                state_d = ST_IDLE;
            end
        end else if (i_start && state_q != ST_RUN) begin
            if (i_load || !is_zero) begin
                state_d = ST_RUN;
            end else if (reload_q != '0) begin
                state_d      = ST_RUN;
                start_reload = 1'b1;
            end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end

        // Load owns the count; otherwise RUN advances on a tick.
        if (i_load) begin
            reload_d  = i_load_value;
            core_load = 1'b1;
        end else if (start_reload) begin
            core_load       = 1'b1;
            core_load_value = reload_q;
        end else if (state_q == ST_RUN && !i_stop && tick) begin
            core_en = 1'b1;
            if (is_one) begin
                done_d = 1'b1;
            end else if (is_zero) begin
                if (!i_auto_reload) begin
                    state_d = ST_IDLE;
                end else if (reload_q == '0) begin
                    done_d = 1'b1;
                end
            end
        end

        done_cnt_d = done_cnt_q;
        if (done_d && done_cnt_q != DONE_CNT_MAX) begin
            done_cnt_d = done_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            reload_q   <= WIDTH'(DEFAULT_LOAD);
            done_q     <= 1'b0;
            done_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            reload_q   <= reload_d;
            done_q     <= done_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign o_busy     = (state_q == ST_RUN);
    assign o_done     = done_q;
    assign o_done_cnt = done_cnt_q;

endmodule
